// File: rtl/rr_arb4_pkg.sv
// rr_arb4_pkg: shared encodings and sizes for the four-way round-robin arbiter.
package rr_arb4_pkg;

   localparam int NREQ  = 4;
   localparam int IDX_W = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

endpackage

// File: rtl/rr_arb4_dec2x4.sv
// dec2x4: enabled 2-to-4 one-hot decoder; all-zero output when disabled.
module dec2x4 (
   input  logic [1:0] i,
   input  logic       EN,
   output logic [3:0] y
);

   assign y = EN ? 4'b0001 << i : 4'b0000;

endmodule

// File: rtl/rr_arb4.sv
// rr_arb4: four-requester round-robin arbiter with bounded hold and registered grant.
module rr_arb4
   import rr_arb4_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_vld
);

   state_e             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic [IDX_W-1:0]   ptr_q;
   logic               vld_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [IDX_W-1:0]   rot_start;
   logic [IDX_W:0]     pick_idle;
   logic [IDX_W:0]     pick_rot;
   logic               rotate;

   // {found, index} of the first set bit of vec scanning upward from start with wrap
   function automatic logic [IDX_W:0] pick(input logic [IDX_W-1:0] start,
                                           input logic [NREQ-1:0]  vec);
      logic [IDX_W:0]   r;
      logic [IDX_W-1:0] k_idx;
      r = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         k_idx = start + IDX_W'(k);
         if (vec[k_idx]) r = {1'b1, k_idx};
      end
      return r;
   endfunction

   assign rot_start = idx_q + IDX_W'(1);
   assign pick_idle = pick(ptr_q, req);
   assign pick_rot  = pick(rot_start, req);
   assign rotate    = !req[idx_q] || (cnt_q == CNT_W'(MAX_HOLD));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         ptr_q   <= '0;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_idle[IDX_W]) begin
                  idx_q   <= pick_idle[IDX_W-1:0];
                  vld_q   <= 1'b1;
                  cnt_q   <= CNT_W'(1);
                  state_q <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (rotate) begin
                  ptr_q <= rot_start;
                  if (pick_rot[IDX_W]) begin
                     idx_q <= pick_rot[IDX_W-1:0];
                     cnt_q <= CNT_W'(1);
                  end else begin
                     vld_q   <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign grant_idx = idx_q;
   assign grant_vld = vld_q;

   dec2x4 u_dec (
      .i  (idx_q),
      .EN (vld_q),
      .y  (grant)
   );

endmodule

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4: directed and random checks of rr_arb4 (MAX_HOLD=4 and MAX_HOLD=1) against a reference model.
module tb_rr_arb4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] g0, g1;
   logic [1:0] i0, i1;
   logic       v0, v1;
   int         vectors = 0;
   int         miscompares = 0;

   int m_idx[2];
   int m_ptr[2];
   int m_hold[2];
   bit m_vld[2];
   int m_max[2] = '{4, 1};

   always #5 clk = ~clk;

   rr_arb4 #(.MAX_HOLD(4), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .req(req), .grant(g0), .grant_idx(i0), .grant_vld(v0)
   );

   rr_arb4 #(.MAX_HOLD(1), .CNT_W(2)) u_dut1 (
      .clk(clk), .rst(rst), .req(req), .grant(g1), .grant_idx(i1), .grant_vld(v1)
   );

   function automatic int first_from(int s, logic [3:0] v);
      for (int k = 0; k < 4; k++)
         if (v[(s + k) % 4]) return (s + k) % 4;
      return -1;
   endfunction

   task automatic model_edge(int n, logic r_rst, logic [3:0] r);
      int f;
      if (r_rst) begin
         m_vld[n] = 0; m_idx[n] = 0; m_ptr[n] = 0; m_hold[n] = 0;
      end else if (!m_vld[n]) begin
         f = first_from(m_ptr[n], r);
         if (f >= 0) begin
            m_vld[n] = 1; m_idx[n] = f; m_hold[n] = 1;
         end
      end else if (r[m_idx[n]] && m_hold[n] < m_max[n]) begin
         m_hold[n]++;
      end else begin
         m_ptr[n] = (m_idx[n] + 1) % 4;
         f = first_from(m_ptr[n], r);
         if (f >= 0) begin
            m_idx[n] = f; m_hold[n] = 1;
         end else begin
            m_vld[n] = 0;
         end
      end
   endtask

   task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [3:0] eg0, eg1;
      eg0 = m_vld[0] ? 4'(1 << m_idx[0]) : 4'b0000;
      eg1 = m_vld[1] ? 4'(1 << m_idx[1]) : 4'b0000;
      chk("h4_grant", g0, eg0);
      chk("h4_vld", {3'b0, v0}, {3'b0, m_vld[0]});
      if (m_vld[0]) chk("h4_idx", {2'b0, i0}, 4'(m_idx[0]));
      chk("h1_grant", g1, eg1);
      chk("h1_vld", {3'b0, v1}, {3'b0, m_vld[1]});
      if (m_vld[1]) chk("h1_idx", {2'b0, i1}, 4'(m_idx[1]));
   endtask

   task automatic step(logic [3:0] r, logic r_rst);
      @(negedge clk);
      req = r;
      rst = r_rst;
      @(posedge clk);
      model_edge(0, r_rst, r);
      model_edge(1, r_rst, r);
      #1;
      check_model();
   endtask

   initial begin
      logic [3:0] rq;
      // reset then idle
      step(4'b0000, 1'b1);
      step(4'b0000, 1'b1);
      for (int c = 0; c < 5; c++) begin
         step(4'b0000, 1'b0);
         chk("idle_grant", g0, 4'b0000);
         chk("idle_idx", {2'b0, i0}, 4'b0000);
         chk("idle_vld", {3'b0, v0}, 4'b0000);
      end
      // single request held past expiry
      for (int c = 0; c < 10; c++) begin
         step(4'b0100, 1'b0);
         chk("single_grant", g0, 4'b0100);
         chk("single_idx", {2'b0, i0}, 4'b0010);
      end
      step(4'b0000, 1'b0);
      chk("single_drop_vld", {3'b0, v0}, 4'b0000);
      // full contention from reset release
      step(4'b1111, 1'b1);
      for (int c = 0; c < 17; c++) begin
         step(4'b1111, 1'b0);
         chk("contention", g0, 4'(1 << ((c / 4) % 4)));
         chk("contention_h1", g1, 4'(1 << (c % 4)));
      end
      // early release handoff
      step(4'b0000, 1'b1);
      step(4'b0011, 1'b0);
      step(4'b0011, 1'b0);
      chk("early_own0", g0, 4'b0001);
      step(4'b0010, 1'b0);
      chk("early_handoff", g0, 4'b0010);
      chk("early_idx", {2'b0, i0}, 4'b0001);
      chk("early_vld", {3'b0, v0}, 4'b0001);
      // fairness wrap from owner 3
      step(4'b0000, 1'b1);
      step(4'b1000, 1'b0);
      chk("wrap_own3", g0, 4'b1000);
      for (int c = 0; c < 3; c++) step(4'b1001, 1'b0);
      chk("wrap_still3", g0, 4'b1000);
      step(4'b1001, 1'b0);
      chk("wrap_to0", g0, 4'b0001);
      step(4'b1000, 1'b0);
      chk("wrap_back3", g0, 4'b1000);
      // reset mid-grant with owner 2 at hold 3
      step(4'b0000, 1'b1);
      for (int c = 0; c < 11; c++) step(4'b1111, 1'b0);
      chk("mid_own2", g0, 4'b0100);
      step(4'b1111, 1'b1);
      chk("mid_rst_grant", g0, 4'b0000);
      chk("mid_rst_idx", {2'b0, i0}, 4'b0000);
      chk("mid_rst_vld", {3'b0, v0}, 4'b0000);
      step(4'b1111, 1'b0);
      chk("mid_after_rst", g0, 4'b0001);
      // random traffic with sticky requests and rare resets
      rq = 4'b0000;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
         step(rq, $urandom_range(0, 199) == 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
